// File: rtl/mlp_layer_sequencer.sv
// mlp_layer_sequencer: walks the three MLP layers issuing one MAC term per input neuron per output neuron,
// with bubbles between layers so each layer's last write-back lands before the next layer reads it.
module mlp_layer_sequencer #(
    parameter int L0_IN      = 784,
    parameter int L0_OUT     = 64,
    parameter int L1_OUT     = 32,
    parameter int L2_OUT     = 10,
    parameter int PIPE_DEPTH = 4,
    parameter int NA_W       = 12,
    parameter int WA_W       = 16,
    parameter int BA_W       = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            stall,
    output logic            issue_valid,
    output logic [NA_W-1:0] input_neuron_addr,
    output logic [WA_W-1:0] input_weight_addr,
    output logic [BA_W-1:0] bias_addr,
    output logic            first_term,
    output logic            write_neuron,
    output logic [NA_W-1:0] output_neuron_addr,
    output logic [1:0]      layer_idx,
    output logic            relu_en,
    output logic            busy,
    output logic            done
);
    typedef enum logic [2:0] {IDLE, ISSUE, GAP, DRAIN, DONE} state_t;
    state_t state, state_nx;
    logic [31:0] i, j, cnt, in_base, in_len, out_len;
    logic [WA_W-1:0] wt;
    logic [BA_W-1:0] bias;
    logic [1:0] layer;
    logic act, last_i, last_j;

    always_comb begin
        in_len             = layer == 2'd0 ? 32'(L0_IN)  : layer == 2'd1 ? 32'(L0_OUT) : 32'(L1_OUT);
        out_len            = layer == 2'd0 ? 32'(L0_OUT) : layer == 2'd1 ? 32'(L1_OUT) : 32'(L2_OUT);
        in_base            = layer == 2'd0 ? 32'd0       : layer == 2'd1 ? 32'(L0_IN)  : 32'(L0_IN + L0_OUT);
        act                = state != IDLE;
        last_i             = i == in_len - 32'd1;
        last_j             = j == out_len - 32'd1;
        issue_valid        = state == ISSUE && !stall;
        first_term         = issue_valid && i == 32'd0;
        write_neuron       = issue_valid && last_i;
        input_neuron_addr  = act ? NA_W'(in_base + i) : '0;
        output_neuron_addr = act ? NA_W'(in_base + in_len + j) : '0;
        input_weight_addr  = act ? wt : '0;
        bias_addr          = act ? bias : '0;
        layer_idx          = act ? layer : 2'd0;
        relu_en            = act && layer != 2'd2;
        busy               = act;
        done               = state == DONE;
        state_nx           = state;
        // GAP spans PIPE_DEPTH bubbles; DRAIN spans PIPE_DEPTH-1 so DONE coincides with the final write
        case (state)
            IDLE:    if (start) state_nx = ISSUE;
            ISSUE:   if (write_neuron && last_j) state_nx = layer == 2'd2 ? DRAIN : GAP;
            GAP:     if (!stall && cnt == 32'(PIPE_DEPTH - 1)) state_nx = ISSUE;
            DRAIN:   if (!stall && cnt == 32'(PIPE_DEPTH - 2)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            cnt   <= '0;
            wt    <= '0;
            bias  <= '0;
            layer <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                i     <= '0;
                j     <= '0;
                cnt   <= '0;
                wt    <= '0;
                bias  <= '0;
                layer <= '0;
            end else if (issue_valid) begin
                wt <= wt + WA_W'(1);
                if (last_i) begin
                    i    <= '0;
                    bias <= bias + BA_W'(1);
                    j    <= last_j ? 32'd0 : j + 32'd1;
                    if (last_j) layer <= layer == 2'd2 ? layer : layer + 2'd1;
                end else begin
                    i <= i + 32'd1;
                end
            end else if ((state == GAP || state == DRAIN) && !stall) begin
                cnt <= state_nx == state ? cnt + 32'd1 : 32'd0;
            end
        end
    end
endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// tb_mlp_layer_sequencer: directed and randomized runs checked against a per-cycle trace built from the layer walk.
module tb_mlp_layer_sequencer;
    localparam int L0_IN = 4, L0_OUT = 3, L1_OUT = 2, L2_OUT = 2, PD = 3;
    localparam int NA_W = 12, WA_W = 16, BA_W = 8;

    logic clk = 0, reset = 0, start = 0, stall = 0;
    logic issue_valid, first_term, write_neuron, relu_en, busy, done;
    logic [NA_W-1:0] input_neuron_addr, output_neuron_addr;
    logic [WA_W-1:0] input_weight_addr;
    logic [BA_W-1:0] bias_addr;
    logic [1:0] layer_idx;

    mlp_layer_sequencer #(.L0_IN(L0_IN), .L0_OUT(L0_OUT), .L1_OUT(L1_OUT), .L2_OUT(L2_OUT),
                          .PIPE_DEPTH(PD), .NA_W(NA_W), .WA_W(WA_W), .BA_W(BA_W)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .issue_valid(issue_valid), .input_neuron_addr(input_neuron_addr),
        .input_weight_addr(input_weight_addr), .bias_addr(bias_addr),
        .first_term(first_term), .write_neuron(write_neuron),
        .output_neuron_addr(output_neuron_addr), .layer_idx(layer_idx),
        .relu_en(relu_en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // kind: 0 = MAC term, 1 = bubble, 2 = done cycle
    typedef struct {int kind; int ia; int wa; int ba; int oa; int ly; int ft; int wn;} ent_t;
    ent_t tr[$];
    int checks = 0, errors = 0, t_first = 0, t_done = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, 64'({input_neuron_addr, input_weight_addr, bias_addr, output_neuron_addr, issue_valid,
                      first_term, write_neuron, layer_idx, relu_en, busy, done}), 64'd0);
    endtask

    function automatic void build();
        int in_base = 0, wt = 0, bias = 0;
        int nin[3]  = '{L0_IN, L0_OUT, L1_OUT};
        int nout[3] = '{L0_OUT, L1_OUT, L2_OUT};
        ent_t e;
        for (int l = 0; l < 3; l++) begin
            for (int jj = 0; jj < nout[l]; jj++) begin
                for (int ii = 0; ii < nin[l]; ii++) begin
                    e = '{0, in_base + ii, wt, bias, in_base + nin[l] + jj, l, int'(ii == 0), int'(ii == nin[l] - 1)};
                    tr.push_back(e);
                    wt++;
                end
                bias++;
            end
            for (int b = 0; b < (l < 2 ? PD : PD - 1); b++) begin
                e = '{1, 0, 0, 0, 0, 0, 0, 0};
                tr.push_back(e);
            end
            in_base += nin[l];
        end
        e = '{2, 0, 0, 0, 0, 0, 0, 0};
        tr.push_back(e);
    endfunction

    // mode 0 plain, 1 start+stall then 5-cycle stall at layer1 i=1, 2 start re-pulse, 3 random, 4 reset mid-run
    task automatic run(input int mode);
        int k = 0, cyc = 0, hold = 0;
        ent_t e;
        @(negedge clk);
        start = 1;
        stall = (mode == 1);
        #1 chk_zero("pre_start_idle");
        while (k < tr.size() && cyc < 400) begin
            @(negedge clk);
            start = (mode == 2 && cyc == 10) || (mode == 3 && $urandom_range(7) == 0);
            if (mode == 1) begin
                if (k == 16 && hold < 5) begin
                    stall = 1;
                    hold++;
                end else stall = cyc < 2;
            end else stall = mode == 3 && $urandom_range(3) == 0;
            if (mode == 4 && cyc == 15) begin
                reset = 0;
                start = 0;
                stall = 0;
                #1 chk_zero("reset_mid_run");
                #2 reset = 1;
                return;
            end
            #1 e = tr[k];
            chk("busy", busy, 1);
            if (e.kind == 2) begin
                chk("done_pulse", done, 1);
                chk("done_no_issue", issue_valid, 0);
                t_done = cyc;
                k++;
            end else begin
                chk("done_low", done, 0);
                chk("issue_valid", issue_valid, 64'(e.kind == 0 && !stall));
                if (e.kind == 0) begin
                    chk("in_addr", input_neuron_addr, e.ia);
                    chk("wt_addr", input_weight_addr, e.wa);
                    chk("bias_addr", bias_addr, e.ba);
                    chk("out_addr", output_neuron_addr, e.oa);
                    chk("layer_idx", layer_idx, e.ly);
                    chk("relu_en", relu_en, 64'(e.ly != 2));
                    if (!stall) begin
                        chk("first_term", first_term, e.ft);
                        chk("write_neuron", write_neuron, e.wn);
                        if (k == 0) t_first = cyc;
                        k++;
                    end else begin
                        chk("stall_first", first_term, 0);
                        chk("stall_write", write_neuron, 0);
                    end
                end else if (!stall) k++;
            end
            cyc++;
        end
        chk("run_complete", k, tr.size());
        @(negedge clk);
        start = 0;
        stall = 0;
        #1 chk_zero("post_done_idle");
    endtask

    initial begin
        build();
        repeat (3) @(negedge clk);
        #1 chk_zero("reset_hold");
        @(negedge clk);
        reset = 1;
        repeat (2) @(negedge clk);
        #1 chk_zero("after_release");
        run(0);
        chk("latency_plain", t_done - t_first, 30);
        run(1);
        chk("latency_stall", t_done - t_first, 35);
        run(2);
        chk("latency_restart_ignored", t_done - t_first, 30);
        run(4);
        @(negedge clk);
        #1 chk_zero("idle_after_abort");
        run(0);
        chk("latency_after_abort", t_done - t_first, 30);
        repeat (4) run(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
